rtc_field_editor: RTL and testbench

- Parametrised button-driven editor for RTC/timer register fields; the next generation of the clock/date/timer programming control FSM.
- Supports NUM_GROUPS groups of FIELDS_PER_GROUP fields, for example time, date and timer with sec/min/hour or day/month/year.
- Adds rising-edge button detection, Up/Down auto-repeat, wrap-around Next/Prev navigation, a sequential Init walk and an inactivity timeout.
- Sits between the debounced button synchroniser and the BCD field counters plus register bank.

---
 rtl/rtc_field_editor.sv | 238 +++++++++++++++++++++++
 tb/tb_rtc_field_editor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_field_editor.sv
// Button-driven editor for RTC/timer register fields: selects a field, walks it with
// Next/Prev/OK, and issues Inc/Dec/WE strobes with auto-repeat and an inactivity abort.
module rtc_field_editor #(
    parameter int NUM_GROUPS       = 3,
    parameter int FIELDS_PER_GROUP = 3,
    parameter int ADDR_W           = 4,
    parameter int REPEAT_DELAY     = 8,
    parameter int REPEAT_RATE      = 4,
    parameter int TIMEOUT_CYCLES   = 64,
    localparam int NF = NUM_GROUPS * FIELDS_PER_GROUP,
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
    localparam int FW = (FIELDS_PER_GROUP > 1) ? $clog2(FIELDS_PER_GROUP) : 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_GROUPS-1:0] Grp_Sel,
    input  logic                  Init,
    input  logic                  Up,
    input  logic                  Down,
    input  logic                  Next,
    input  logic                  Prev,
    input  logic                  OK,
    output logic                  Inc,
    output logic                  Dec,
    output logic                  WE,
    output logic [ADDR_W-1:0]     Addr,
    output logic [NF-1:0]         Field_En,
    output logic [GW-1:0]         Group_Idx,
    output logic [FW-1:0]         Field_Idx,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Abort
);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] REP_FIRST  = RW'(1);
    localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST     = GW'(NUM_GROUPS - 1);
    localparam logic [FW-1:0] F_LAST     = FW'(FIELDS_PER_GROUP - 1);
    localparam int B_UP = 4, B_DN = 3, B_NX = 2, B_PV = 1, B_OK = 0;

    typedef enum logic [1:0] {IDLE = 2'd0, EDIT = 2'd1, INIT = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [4:0]        btn_q, btn_lvl, btn_edge;
    logic              any_edge;
    logic [GW-1:0]     g_q, g_d, g_n, nxt_g, prv_g, sel_g;
    logic [FW-1:0]     f_q, f_d, f_n, nxt_f, prv_f;
    logic              sel_hit;
    logic [RW-1:0]     up_cnt_q, up_cnt_d, up_cnt_n, dn_cnt_q, dn_cnt_d, dn_cnt_n;
    logic              rep_up, rep_dn;
    logic [TW-1:0]     to_q, to_d;
    logic              inc_d, dec_d, done_d, abort_d;
    logic [ADDR_W-1:0] addr_d;
    logic [NF-1:0]     fen_d;
    logic              inc_q, dec_q, done_q, abort_q, busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NF-1:0]     fen_q;

    assign btn_lvl  = {Up, Down, Next, Prev, OK};
    assign btn_edge = btn_lvl & ~btn_q;
    assign any_edge = |btn_edge;

    // Lowest-index group request and wrap-around neighbours of the current field.
    always_comb begin
        sel_hit = 1'b0;
        sel_g   = GW'(0);
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (Grp_Sel[i]) begin
                sel_hit = 1'b1;
                sel_g   = GW'(i);
            end else begin
                sel_hit = sel_hit;
                sel_g   = sel_g;
            end
        end
        nxt_g = g_q;
        prv_g = g_q;
        // Only the Init walk crosses group boundaries.
        if (f_q == F_LAST) begin
            nxt_f = FW'(0);
            if (state_q == INIT) nxt_g = (g_q == G_LAST) ? GW'(0) : g_q + GW'(1);
            else                 nxt_g = g_q;
        end else begin
            nxt_f = f_q + FW'(1);
        end
        if (f_q == FW'(0)) begin
            prv_f = F_LAST;
            if (state_q == INIT) prv_g = (g_q == GW'(0)) ? G_LAST : g_q - GW'(1);
            else                 prv_g = g_q;
        end else begin
            prv_f = f_q - FW'(1);
        end
    end

    // Auto-repeat hold counters: zero means no run started by an edge; Up beats Down.
    always_comb begin
        rep_up   = 1'b0;
        rep_dn   = 1'b0;
        up_cnt_n = RW'(0);
        dn_cnt_n = RW'(0);
        if (Up) begin
            if (btn_edge[B_UP]) begin
                rep_up   = 1'b1;
                up_cnt_n = REP_FIRST;
            end else if (up_cnt_q == RW'(0)) begin
                up_cnt_n = RW'(0);
            end else if (up_cnt_q == REP_FIRE) begin
                rep_up   = 1'b1;
                up_cnt_n = REP_RELOAD;
            end else begin
                up_cnt_n = up_cnt_q + RW'(1);
            end
        end else if (Down) begin
            if (btn_edge[B_DN]) begin
                rep_dn   = 1'b1;
                dn_cnt_n = REP_FIRST;
            end else if (dn_cnt_q == RW'(0)) begin
                dn_cnt_n = RW'(0);
            end else if (dn_cnt_q == REP_FIRE) begin
                rep_dn   = 1'b1;
                dn_cnt_n = REP_RELOAD;
            end else begin
                dn_cnt_n = dn_cnt_q + RW'(1);
            end
        end else begin
            up_cnt_n = RW'(0);
            dn_cnt_n = RW'(0);
        end
    end

    // Next-state and next-output decode; one action per cycle.
    always_comb begin
        state_d  = state_q;
        g_n      = g_q;
        f_n      = f_q;
        to_d     = TW'(0);
        up_cnt_d = RW'(0);
        dn_cnt_d = RW'(0);
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                g_n = GW'(0);
                f_n = FW'(0);
                if (Init) begin
                    state_d = INIT;
                end else if (sel_hit) begin
                    state_d = EDIT;
                    g_n     = sel_g;
                end else begin
                    state_d = IDLE;
                end
            end
            EDIT, INIT: begin
                up_cnt_d = up_cnt_n;
                dn_cnt_d = dn_cnt_n;
                to_d     = any_edge ? TW'(0) : to_q + TW'(1);
                if (!any_edge && (to_q == TO_LAST)) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (btn_edge[B_OK]) begin
                    if ((state_q == EDIT) || ((g_q == G_LAST) && (f_q == F_LAST))) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        g_n = nxt_g;
                        f_n = nxt_f;
                    end
                end else if (btn_edge[B_NX]) begin
                    g_n = nxt_g;
                    f_n = nxt_f;
                end else if (btn_edge[B_PV]) begin
                    g_n = prv_g;
                    f_n = prv_f;
                end else begin
                    inc_d = rep_up;
                    dec_d = rep_dn;
                end
            end
            default: state_d = IDLE;
        endcase
        g_d    = (state_d == IDLE) ? GW'(0) : g_n;
        f_d    = (state_d == IDLE) ? FW'(0) : f_n;
        addr_d = (state_d == IDLE) ? ADDR_W'(NF)
                                   : ADDR_W'(g_d) * ADDR_W'(FIELDS_PER_GROUP) + ADDR_W'(f_d);
        fen_d  = (state_d == IDLE) ? NF'(0) : (NF'(1) << addr_d);
    end

    // State and output registers; button history reloads even in reset.
    always_ff @(posedge Clock) begin
        btn_q <= btn_lvl;
        if (Reset) begin
            state_q  <= IDLE;
            g_q      <= GW'(0);
            f_q      <= FW'(0);
            up_cnt_q <= RW'(0);
            dn_cnt_q <= RW'(0);
            to_q     <= TW'(0);
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= ADDR_W'(NF);
            fen_q    <= NF'(0);
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            f_q      <= f_d;
            up_cnt_q <= up_cnt_d;
            dn_cnt_q <= dn_cnt_d;
            to_q     <= to_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            busy_q   <= (state_d != IDLE);
            addr_q   <= addr_d;
            fen_q    <= fen_d;
        end
    end

    assign Inc       = inc_q;
    assign Dec       = dec_q;
    assign WE        = inc_q | dec_q;
    assign Addr      = addr_q;
    assign Field_En  = fen_q;
    assign Group_Idx = g_q;
    assign Field_Idx = f_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Abort     = abort_q;
endmodule

// File: tb/tb_rtc_field_editor.sv
// Self-checking bench for rtc_field_editor: vector table, directed corner sequences and
// randomized stimulus against a behavioural model of the editing rules.
module tb_rtc_field_editor;
    localparam int G = 3, F = 3, AW = 4, RD = 8, RR = 4, TC = 64, NF = 9;

    logic Clock = 1'b0;
    logic Reset;
    logic [2:0] Grp_Sel;
    logic Init, Up, Down, Next, Prev, OK;
    logic Inc, Dec, WE, Busy, Done, Abort;
    logic [AW-1:0] Addr;
    logic [NF-1:0] Field_En;
    logic [1:0] Group_Idx, Field_Idx;

    rtc_field_editor #(
        .NUM_GROUPS(G), .FIELDS_PER_GROUP(F), .ADDR_W(AW),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_CYCLES(TC)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Grp_Sel(Grp_Sel), .Init(Init),
        .Up(Up), .Down(Down), .Next(Next), .Prev(Prev), .OK(OK),
        .Inc(Inc), .Dec(Dec), .WE(WE), .Addr(Addr), .Field_En(Field_En),
        .Group_Idx(Group_Idx), .Field_Idx(Field_Idx),
        .Busy(Busy), .Done(Done), .Abort(Abort)
    );

    always #5 Clock = ~Clock;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 edit, 2 init; pos is the linear field index.
    int m_mode = 0, m_pos = 0, m_hu = -1, m_hd = -1, m_quiet = 0;
    bit m_pu, m_pd, m_pn, m_pp, m_pok;
    bit e_inc, e_dec, e_done, e_abort;

    typedef struct {
        logic [2:0] gs;
        logic up, nx, pv, ok;
        logic [3:0] addr;
        logic inc, done, busy;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic int lowest(input logic [2:0] gs);
        for (int i = 0; i < 3; i++) if (gs[i]) return i;
        return 0;
    endfunction

    function automatic bit is_pulse(input int h);
        if (h < 0) return 1'b0;
        return (h == 0) || (h >= RD && ((h - RD) % RR) == 0);
    endfunction

    function automatic int step(input int pos, input int d);
        if (m_mode == 2) return (pos + NF + d) % NF;
        return (pos / F) * F + ((pos % F + F + d) % F);
    endfunction

    task automatic model_step();
        bit eu, ed, en, ep, eok, anye, up_p, dn_p;
        eu = Up && !m_pu;  ed = Down && !m_pd;  en = Next && !m_pn;
        ep = Prev && !m_pp; eok = OK && !m_pok;
        anye = eu || ed || en || ep || eok;
        e_inc = 1'b0; e_dec = 1'b0; e_done = 1'b0; e_abort = 1'b0;
        up_p = 1'b0; dn_p = 1'b0;
        if (Reset) begin
            m_mode = 0; m_pos = 0; m_hu = -1; m_hd = -1; m_quiet = 0;
        end else if (m_mode == 0) begin
            m_hu = -1; m_hd = -1; m_quiet = 0;
            if (Init) begin m_mode = 2; m_pos = 0; end
            else if (Grp_Sel != 3'b000) begin m_mode = 1; m_pos = lowest(Grp_Sel) * F; end
        end else begin
            if (Up) begin
                m_hd = -1;
                if (eu) m_hu = 0; else if (m_hu >= 0) m_hu++;
                up_p = is_pulse(m_hu);
            end else begin
                m_hu = -1;
                if (Down) begin
                    if (ed) m_hd = 0; else if (m_hd >= 0) m_hd++;
                    dn_p = is_pulse(m_hd);
                end else m_hd = -1;
            end
            m_quiet = anye ? 0 : m_quiet + 1;
            if (m_quiet == TC) begin
                e_abort = 1'b1; m_mode = 0;
            end else if (eok) begin
                if (m_mode == 1 || m_pos == NF - 1) begin e_done = 1'b1; m_mode = 0; end
                else m_pos = (m_pos + 1) % NF;
            end else if (en) m_pos = step(m_pos, 1);
            else if (ep) m_pos = step(m_pos, -1);
            else begin e_inc = up_p; e_dec = dn_p; end
        end
        m_pu = Up; m_pd = Down; m_pn = Next; m_pp = Prev; m_pok = OK;
    endtask

    function automatic logic [31:0] model_vec();
        logic [3:0] a; logic [8:0] fe; logic [1:0] gi, fi; logic [8:0] one;
        one = 9'd1;
        if (m_mode == 0) begin a = 4'd9; fe = 9'd0; gi = 2'd0; fi = 2'd0; end
        else begin a = 4'(m_pos); fe = one << m_pos; gi = 2'(m_pos / F); fi = 2'(m_pos % F); end
        return 32'({e_inc, e_dec, e_inc | e_dec, (m_mode != 0), e_done, e_abort, a, fe, gi, fi});
    endfunction

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
        chk("model", 32'({Inc, Dec, WE, Busy, Done, Abort, Addr, Field_En, Group_Idx, Field_Idx}),
            model_vec());
    endtask

    task automatic set_in(input logic [2:0] gs, input logic ini, input logic u, input logic d,
                          input logic n, input logic p, input logic o);
        Grp_Sel = gs; Init = ini; Up = u; Down = d; Next = n; Prev = p; OK = o;
    endtask

    initial begin
        int mask, bad, acnt, afirst, dseen;
        tbl[0]  = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0};

        // Reset held with Up high, then Up kept held: no edge, no strobe.
        Reset = 1'b1;
        set_in(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("reset_state", 32'({Addr, Busy, WE, Done, Abort, Field_En}), 32'({4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0}));
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_through_reset", 32'({Inc, WE, Busy, Addr}), 32'({1'b0, 1'b0, 1'b0, 4'd9}));
        end
        Up = 1'b0;
        tick();

        // Navigation table.
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].gs, 1'b0, tbl[i].up, 1'b0, tbl[i].nx, tbl[i].pv, tbl[i].ok);
            tick();
            chk($sformatf("tbl%0d", i), 32'({Addr, Inc, Done, Busy}),
                32'({tbl[i].addr, tbl[i].inc, tbl[i].done, tbl[i].busy}));
        end

        // Auto-repeat cadence with Up held 30 cycles.
        set_in(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mask = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Inc === 1'b1) mask |= (1 << i);
            if (WE !== Inc || Addr !== 4'd0 || Dec !== 1'b0) bad++;
        end
        chk("repeat_mask", 32'(mask), 32'h1111_1101);
        chk("repeat_we_addr", 32'(bad), 32'd0);
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("repeat_ok_done", 32'({Done, Busy}), 32'({1'b1, 1'b0}));
        OK = 1'b0;
        tick();

        // Up+Down held with OK and Next edges together: OK wins, no strobe.
        set_in(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("both_held_up_wins", 32'({Inc, Dec}), 32'({1'b1, 1'b0}));
        set_in(3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ok_beats_all", 32'({Done, Inc, Dec, WE, Busy, Addr}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9}));
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("after_ok_idle", 32'({Done, Busy}), 32'd0);

        // Init walk through all nine fields.
        Init = 1'b1;
        tick();
        Init = 1'b0;
        chk("init_entry", 32'({Addr, Busy, Group_Idx, Field_Idx}), 32'({4'd0, 1'b1, 2'd0, 2'd0}));
        for (int k = 0; k < 9; k++) begin
            OK = 1'b1;
            tick();
            if (k < 8) chk($sformatf("init_ok%0d", k), 32'({Addr, Done}), 32'({4'(k + 1), 1'b0}));
            else       chk("init_final", 32'({Addr, Done, Busy}), 32'({4'd9, 1'b1, 1'b0}));
            OK = 1'b0;
            tick();
        end

        // Inactivity timeout.
        Grp_Sel = 3'b010;
        tick();
        Grp_Sel = 3'b000;
        acnt = 0; afirst = -1; dseen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (Abort === 1'b1) begin acnt++; afirst = i; end
            if (Done === 1'b1) dseen++;
        end
        chk("timeout_count", 32'(acnt), 32'd1);
        chk("timeout_cycle", 32'(afirst), 32'd63);
        chk("timeout_state", 32'({4'(dseen), Busy, Addr}), 32'({4'd0, 1'b0, 4'd9}));

        // Reset mid-edit together with an Up edge.
        Grp_Sel = 3'b001;
        tick();
        Grp_Sel = 3'b000; Up = 1'b1; Reset = 1'b1;
        tick();
        chk("mid_edit_reset", 32'({WE, Busy, Addr}), 32'({1'b0, 1'b0, 4'd9}));
        Reset = 1'b0; Up = 1'b0;
        tick();

        // Randomized stimulus with periodic quiet stretches.
        for (int c = 0; c < 3000; c++) begin
            if ((c % 700) < 600) begin
                if ($urandom_range(0, 7) == 0) Up = ~Up;
                if ($urandom_range(0, 7) == 0) Down = ~Down;
                if ($urandom_range(0, 9) == 0) Next = ~Next;
                if ($urandom_range(0, 9) == 0) Prev = ~Prev;
                if ($urandom_range(0, 15) == 0) OK = ~OK;
            end
            Grp_Sel = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            Init = ($urandom_range(0, 31) == 0);
            Reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
